// File: rtl/lsu_mem_interface_if.sv
// Word-wide request/grant/response data-memory bus between the LSU and memory.
// The master side (the LSU) raises a request and holds the command until it is
// granted. For loads, the master then waits for rvalid with the read word.
interface lsu_mem_interface_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) ();

  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [3:0]            mem_be_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic                  mem_gnt_i;
  logic                  mem_rvalid_i;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  modport master (
    output mem_req_o,
    output mem_we_o,
    output mem_addr_o,
    output mem_be_o,
    output mem_wdata_o,
    input  mem_gnt_i,
    input  mem_rvalid_i,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_we_o,
    input  mem_addr_o,
    input  mem_be_o,
    input  mem_wdata_o,
    output mem_gnt_i,
    output mem_rvalid_i,
    output mem_rdata_i
  );

endinterface

// File: rtl/lsu_mem_interface.sv
// Load/store unit placed after decode. It takes the decoder's load/store width
// codes, the ALU address and the rs2 data, and runs one memory bus transaction.
// Loads return aligned, sign- or zero-extended data together with a done pulse.
module lsu_mem_interface #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  is_load_i,
  input  logic [2:0]            load_ctrl_i,
  input  logic [1:0]            store_ctrl_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  misalign_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  lsu_mem_interface_if.master   mem
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_e;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

  state_e                state_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  misalign_q;
  logic                  req_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            be_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [2:0]            lctrl_q;
  logic [1:0]            off_q;

  logic                  isStore;
  logic                  isLoad;
  logic                  misaligned;
  size_e                 size;
  logic [1:0]            off;
  logic [3:0]            beD;
  logic [DATA_WIDTH-1:0] wdataD;
  logic [DATA_WIDTH-1:0] loadData;
  logic [7:0]            byteSel;
  logic [15:0]           halfSel;

  assign off = addr_i[1:0];

  // Classify the incoming operation. A store code wins over is_load_i. Then
  // derive its access size, alignment, byte lanes and replicated write data.
  always_comb begin
    isStore    = (store_ctrl_i != 2'b00);
    isLoad     = 1'b0;
    size       = SZ_WORD;
    misaligned = 1'b0;
    beD        = 4'b1111;
    wdataD     = wdata_i;
    if (!isStore && is_load_i) begin
      unique case (load_ctrl_i)
        3'b011, 3'b111, 3'b010, 3'b110, 3'b001: isLoad = 1'b1;
        default:                                isLoad = 1'b0;
      endcase
    end
    if (isStore) begin
      unique case (store_ctrl_i)
        2'b11:   size = SZ_BYTE;
        2'b10:   size = SZ_HALF;
        default: size = SZ_WORD;
      endcase
    end else begin
      unique case (load_ctrl_i)
        3'b011, 3'b111: size = SZ_BYTE;
        3'b010, 3'b110: size = SZ_HALF;
        default:        size = SZ_WORD;
      endcase
    end
    unique case (size)
      SZ_BYTE: begin
        beD    = 4'b0001 << off;
        wdataD = {4{wdata_i[7:0]}};
      end
      SZ_HALF: begin
        beD        = 4'b0011 << off;
        wdataD     = {2{wdata_i[15:0]}};
        misaligned = (isStore || isLoad) && off[0];
      end
      default: begin
        beD        = 4'b1111;
        wdataD     = wdata_i;
        misaligned = (isStore || isLoad) && (off != 2'b00);
      end
    endcase
  end

  // Pick the addressed byte or halfword out of the read word. Then sign- or
  // zero-extend it according to the load code captured at acceptance.
  always_comb begin
    unique case (off_q)
      2'd0:    byteSel = mem.mem_rdata_i[7:0];
      2'd1:    byteSel = mem.mem_rdata_i[15:8];
      2'd2:    byteSel = mem.mem_rdata_i[23:16];
      default: byteSel = mem.mem_rdata_i[31:24];
    endcase
    halfSel = off_q[1] ? mem.mem_rdata_i[31:16] : mem.mem_rdata_i[15:0];
    unique case (lctrl_q)
      3'b011:  loadData = {{(DATA_WIDTH-8){byteSel[7]}}, byteSel};
      3'b111:  loadData = {{(DATA_WIDTH-8){1'b0}}, byteSel};
      3'b010:  loadData = {{(DATA_WIDTH-16){halfSel[15]}}, halfSel};
      3'b110:  loadData = {{(DATA_WIDTH-16){1'b0}}, halfSel};
      default: loadData = mem.mem_rdata_i;
    endcase
  end

  // Transaction FSM with registered outputs. Operands are latched only at
  // acceptance, so later input changes are ignored. A new start is also
  // accepted in the DONE cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      lctrl_q    <= '0;
      off_q      <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          state_q    <= IDLE;
          busy_q     <= 1'b0;
          misalign_q <= 1'b0;
          if (start_i) begin
            lctrl_q <= load_ctrl_i;
            off_q   <= off;
            if (!(isStore || isLoad) || misaligned) begin
              state_q    <= DONE;
              done_q     <= 1'b1;
              misalign_q <= misaligned;
            end else begin
              state_q <= REQ;
              busy_q  <= 1'b1;
              req_q   <= 1'b1;
              we_q    <= isStore;
              addr_q  <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
              be_q    <= beD;
              wdata_q <= wdataD;
            end
          end
        end
        REQ: begin
          if (mem.mem_gnt_i) begin
            req_q <= 1'b0;
            if (we_q) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= WAIT_RSP;
            end
          end
        end
        WAIT_RSP: begin
          if (mem.mem_rvalid_i) begin
            rdata_q <= loadData;
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign misalign_o      = misalign_q;
  assign rdata_o         = rdata_q;
  assign mem.mem_req_o   = req_q;
  assign mem.mem_we_o    = we_q;
  assign mem.mem_addr_o  = addr_q;
  assign mem.mem_be_o    = be_q;
  assign mem.mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_lsu_mem_interface.sv
// Directed testbench for lsu_mem_interface. It runs a table of single
// transactions with immediate grant and next-cycle rvalid. It then runs
// hand-written sequences for delayed handshakes, DONE-cycle acceptance, and
// reset taken mid-transaction.
module tb_lsu_mem_interface;

  typedef struct {
    logic        isLoad;
    logic [2:0]  lctrl;
    logic [1:0]  sctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] memRdata;
    logic        expReq;
    logic        expWe;
    logic        expMis;
    logic [31:0] expAddr;
    logic [3:0]  expBe;
    logic [31:0] expWdata;
    logic [31:0] expRdata;
  } vec_t;

  logic        clk_i;
  logic        rst_ni;
  logic        start_i;
  logic        is_load_i;
  logic [2:0]  load_ctrl_i;
  logic [1:0]  store_ctrl_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        busy_o;
  logic        done_o;
  logic        misalign_o;
  logic [31:0] rdata_o;

  int          assertCount = 0;
  int          failCount   = 0;
  logic [31:0] lastRdata   = 32'h0;
  vec_t        vecs[19];

  lsu_mem_interface_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) memIf ();

  lsu_mem_interface #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .is_load_i    (is_load_i),
    .load_ctrl_i  (load_ctrl_i),
    .store_ctrl_i (store_ctrl_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .misalign_o   (misalign_o),
    .rdata_o      (rdata_o),
    .mem          (memIf.master)
  );

  // 10 ns clock
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Hard time limit so a stuck run still terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string what, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", what, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic driveOp(input logic isLoad, input logic [2:0] lctrl, input logic [1:0] sctrl,
                         input logic [31:0] addr, input logic [31:0] wdata);
    is_load_i    = isLoad;
    load_ctrl_i  = lctrl;
    store_ctrl_i = sctrl;
    addr_i       = addr;
    wdata_i      = wdata;
  endtask

  // One transaction. The grant comes in the request cycle and rvalid in the
  // cycle after it. Operands are scrambled right after acceptance.
  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge clk_i);
    driveOp(v.isLoad, v.lctrl, v.sctrl, v.addr, v.wdata);
    memIf.mem_rdata_i = v.memRdata;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    driveOp(1'b0, 3'b000, 2'b01, 32'hFFFF_FFFF, 32'h5555_5555);
    if (v.expReq) begin
      checkOutput($sformatf("v%0d req", idx), {31'b0, memIf.mem_req_o}, 32'd1);
      checkOutput($sformatf("v%0d we", idx), {31'b0, memIf.mem_we_o}, {31'b0, v.expWe});
      checkOutput($sformatf("v%0d addr", idx), memIf.mem_addr_o, v.expAddr);
      checkOutput($sformatf("v%0d be", idx), {28'b0, memIf.mem_be_o}, {28'b0, v.expBe});
      if (v.expWe)
        checkOutput($sformatf("v%0d wdata", idx), memIf.mem_wdata_o, v.expWdata);
      checkOutput($sformatf("v%0d busy req", idx), {31'b0, busy_o}, 32'd1);
      checkOutput($sformatf("v%0d done req", idx), {31'b0, done_o}, 32'd0);
      memIf.mem_gnt_i = 1'b1;
      tick();
      memIf.mem_gnt_i = 1'b0;
      if (!v.expWe) begin
        checkOutput($sformatf("v%0d busy wait", idx), {31'b0, busy_o}, 32'd1);
        checkOutput($sformatf("v%0d done wait", idx), {31'b0, done_o}, 32'd0);
        checkOutput($sformatf("v%0d req wait", idx), {31'b0, memIf.mem_req_o}, 32'd0);
        memIf.mem_rvalid_i = 1'b1;
        tick();
        memIf.mem_rvalid_i = 1'b0;
        lastRdata = v.expRdata;
      end
    end
    checkOutput($sformatf("v%0d done", idx), {31'b0, done_o}, 32'd1);
    checkOutput($sformatf("v%0d misalign", idx), {31'b0, misalign_o}, {31'b0, v.expMis});
    checkOutput($sformatf("v%0d busy done", idx), {31'b0, busy_o}, 32'd0);
    checkOutput($sformatf("v%0d req done", idx), {31'b0, memIf.mem_req_o}, 32'd0);
    checkOutput($sformatf("v%0d rdata", idx), rdata_o, lastRdata);
    tick();
    checkOutput($sformatf("v%0d done drop", idx), {31'b0, done_o}, 32'd0);
  endtask

  initial begin
    //            ld  lctrl   sctrl  addr          wdata         memRdata      req  we   mis  expAddr       be       expWdata      expRdata
    vecs[0]  = '{1'b0, 3'b000, 2'b01, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 32'h0};
    vecs[1]  = '{1'b0, 3'b000, 2'b11, 32'h0000_0203, 32'h0000_00A5, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0000_0200, 4'b1000, 32'hA5A5_A5A5, 32'h0};
    vecs[2]  = '{1'b0, 3'b000, 2'b10, 32'h0000_0102, 32'h1234_ABCD, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0000_0100, 4'b1100, 32'hABCD_ABCD, 32'h0};
    vecs[3]  = '{1'b1, 3'b011, 2'b00, 32'h0000_0000, 32'h0,         32'h80F0_7F81, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 4'b0001, 32'h0,         32'hFFFF_FF81};
    vecs[4]  = '{1'b1, 3'b111, 2'b00, 32'h0000_0003, 32'h0,         32'h80F0_7F81, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 4'b1000, 32'h0,         32'h0000_0080};
    vecs[5]  = '{1'b1, 3'b010, 2'b00, 32'h0000_0002, 32'h0,         32'h80F0_7F81, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 4'b1100, 32'h0,         32'hFFFF_80F0};
    vecs[6]  = '{1'b1, 3'b110, 2'b00, 32'h0000_0000, 32'h0,         32'h80F0_7F81, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 4'b0011, 32'h0,         32'h0000_7F81};
    vecs[7]  = '{1'b1, 3'b001, 2'b00, 32'h0000_0004, 32'h0,         32'h80F0_7F81, 1'b1, 1'b0, 1'b0, 32'h0000_0004, 4'b1111, 32'h0,         32'h80F0_7F81};
    vecs[8]  = '{1'b1, 3'b001, 2'b00, 32'h0000_0102, 32'h0,         32'h1111_1111, 1'b0, 1'b0, 1'b1, 32'h0,         4'b0000, 32'h0,         32'h0};
    vecs[9]  = '{1'b0, 3'b000, 2'b10, 32'h0000_0101, 32'h0000_1111, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0,         4'b0000, 32'h0,         32'h0};
    vecs[10] = '{1'b1, 3'b000, 2'b00, 32'h0000_0040, 32'h0,         32'h0,        1'b0, 1'b0, 1'b0, 32'h0,         4'b0000, 32'h0,         32'h0};
    vecs[11] = '{1'b1, 3'b001, 2'b10, 32'h0000_03FE, 32'h0000_BEEF, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0000_03FC, 4'b1100, 32'hBEEF_BEEF, 32'h0};
    vecs[12] = '{1'b1, 3'b011, 2'b00, 32'h0000_0001, 32'h0,         32'h80F0_7F81, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 4'b0010, 32'h0,         32'h0000_007F};
    vecs[13] = '{1'b1, 3'b110, 2'b00, 32'h0000_0002, 32'h0,         32'h80F0_7F81, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 4'b1100, 32'h0,         32'h0000_80F0};
    vecs[14] = '{1'b0, 3'b000, 2'b01, 32'h0000_0002, 32'h1234_5678, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0,         4'b0000, 32'h0,         32'h0};
    vecs[15] = '{1'b1, 3'b010, 2'b00, 32'h0000_0003, 32'h0,         32'h2222_2222, 1'b0, 1'b0, 1'b1, 32'h0,         4'b0000, 32'h0,         32'h0};
    vecs[16] = '{1'b1, 3'b111, 2'b00, 32'h0000_0002, 32'h0,         32'h80F0_7F81, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 4'b0100, 32'h0,         32'h0000_00F0};
    vecs[17] = '{1'b0, 3'b000, 2'b11, 32'h0000_0001, 32'hFFFF_FF3C, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0000_0000, 4'b0010, 32'h3C3C_3C3C, 32'h0};
    vecs[18] = '{1'b1, 3'b100, 2'b00, 32'h0000_0000, 32'h0,         32'h0,        1'b0, 1'b0, 1'b0, 32'h0,         4'b0000, 32'h0,         32'h0};

    rst_ni             = 1'b0;
    start_i            = 1'b0;
    driveOp(1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
    memIf.mem_gnt_i    = 1'b0;
    memIf.mem_rvalid_i = 1'b0;
    memIf.mem_rdata_i  = 32'h0;
    tick();
    tick();
    checkOutput("reset busy", {31'b0, busy_o}, 32'd0);
    checkOutput("reset done", {31'b0, done_o}, 32'd0);
    checkOutput("reset misalign", {31'b0, misalign_o}, 32'd0);
    checkOutput("reset rdata", rdata_o, 32'h0);
    checkOutput("reset req", {31'b0, memIf.mem_req_o}, 32'd0);
    checkOutput("reset we", {31'b0, memIf.mem_we_o}, 32'd0);
    checkOutput("reset addr", memIf.mem_addr_o, 32'h0);
    checkOutput("reset be", {28'b0, memIf.mem_be_o}, 32'h0);
    checkOutput("reset wdata", memIf.mem_wdata_o, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();

    for (int i = 0; i < 19; i++) applyStimulus(vecs[i], i);

    // Grant held off 3 cycles and rvalid held off 2 cycles; a start pulse lands mid-request
    @(negedge clk_i);
    driveOp(1'b1, 3'b001, 2'b00, 32'h0000_0008, 32'h0);
    memIf.mem_rdata_i = 32'h1357_9BDF;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("dly req c%0d", k), {31'b0, memIf.mem_req_o}, 32'd1);
      checkOutput($sformatf("dly addr c%0d", k), memIf.mem_addr_o, 32'h0000_0008);
      checkOutput($sformatf("dly be c%0d", k), {28'b0, memIf.mem_be_o}, 32'hF);
      checkOutput($sformatf("dly busy c%0d", k), {31'b0, busy_o}, 32'd1);
      checkOutput($sformatf("dly done c%0d", k), {31'b0, done_o}, 32'd0);
      start_i = (k == 1);
      driveOp(1'b0, 3'b000, 2'b11, 32'h0000_0000, 32'h0000_0077);
      tick();
    end
    start_i = 1'b0;
    driveOp(1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
    checkOutput("dly req at gnt", {31'b0, memIf.mem_req_o}, 32'd1);
    checkOutput("dly addr at gnt", memIf.mem_addr_o, 32'h0000_0008);
    checkOutput("dly we at gnt", {31'b0, memIf.mem_we_o}, 32'd0);
    memIf.mem_gnt_i = 1'b1;
    tick();
    memIf.mem_gnt_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("dly wait busy c%0d", k), {31'b0, busy_o}, 32'd1);
      checkOutput($sformatf("dly wait done c%0d", k), {31'b0, done_o}, 32'd0);
      checkOutput($sformatf("dly wait req c%0d", k), {31'b0, memIf.mem_req_o}, 32'd0);
      tick();
    end
    memIf.mem_rvalid_i = 1'b1;
    tick();
    memIf.mem_rvalid_i = 1'b0;
    lastRdata = 32'h1357_9BDF;
    checkOutput("dly done", {31'b0, done_o}, 32'd1);
    checkOutput("dly rdata", rdata_o, lastRdata);
    memIf.mem_gnt_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput($sformatf("dly after done c%0d", k), {31'b0, done_o}, 32'd0);
      checkOutput($sformatf("dly after busy c%0d", k), {31'b0, busy_o}, 32'd0);
      checkOutput($sformatf("dly after req c%0d", k), {31'b0, memIf.mem_req_o}, 32'd0);
    end
    memIf.mem_gnt_i = 1'b0;

    // A misaligned lw followed by a sw accepted in the DONE cycle
    @(negedge clk_i);
    driveOp(1'b1, 3'b001, 2'b00, 32'h0000_0102, 32'h0);
    start_i = 1'b1;
    tick();
    checkOutput("b2b done mis", {31'b0, done_o}, 32'd1);
    checkOutput("b2b misalign", {31'b0, misalign_o}, 32'd1);
    checkOutput("b2b rdata kept", rdata_o, lastRdata);
    driveOp(1'b0, 3'b000, 2'b01, 32'h0000_0010, 32'hCAFE_F00D);
    tick();
    start_i = 1'b0;
    checkOutput("b2b req", {31'b0, memIf.mem_req_o}, 32'd1);
    checkOutput("b2b addr", memIf.mem_addr_o, 32'h0000_0010);
    checkOutput("b2b wdata", memIf.mem_wdata_o, 32'hCAFE_F00D);
    checkOutput("b2b misalign clr", {31'b0, misalign_o}, 32'd0);
    checkOutput("b2b done low", {31'b0, done_o}, 32'd0);
    memIf.mem_gnt_i = 1'b1;
    tick();
    memIf.mem_gnt_i = 1'b0;
    checkOutput("b2b done sw", {31'b0, done_o}, 32'd1);
    tick();

    // Reset asserted while waiting for rvalid; the late rvalid must not complete anything
    @(negedge clk_i);
    driveOp(1'b1, 3'b001, 2'b00, 32'h0000_000C, 32'h0);
    memIf.mem_rdata_i = 32'hAAAA_5555;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    memIf.mem_gnt_i = 1'b1;
    tick();
    memIf.mem_gnt_i = 1'b0;
    checkOutput("rst busy before", {31'b0, busy_o}, 32'd1);
    rst_ni = 1'b0;
    #1;
    lastRdata = 32'h0;
    checkOutput("rst req", {31'b0, memIf.mem_req_o}, 32'd0);
    checkOutput("rst busy", {31'b0, busy_o}, 32'd0);
    checkOutput("rst rdata", rdata_o, 32'h0);
    checkOutput("rst done", {31'b0, done_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    memIf.mem_rvalid_i = 1'b1;
    tick();
    memIf.mem_rvalid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("rst late done c%0d", k), {31'b0, done_o}, 32'd0);
      checkOutput($sformatf("rst late rdata c%0d", k), rdata_o, lastRdata);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/lsu_mem_interface.md
Name: lsu_mem_interface

Overview:
- Load/store unit sitting directly downstream of the decode/control stage.
- Consumes the decoder's encoded load-width code (3-bit) and store-width code (2-bit), plus the ALU-computed address and the rs2 data.
- Runs one transaction on a word-wide request/grant/response data-memory bus.
- Returns aligned, sign- or zero-extended load data with a one-cycle done pulse.

Parameters:
- DATA_WIDTH, 32, data bus and register width; only 32 is supported.
- ADDR_WIDTH, 32, byte-address width.

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- start_i  in  1  request strobe; accepted only when busy_o=0
- is_load_i  in  1  operation is a load (decoder result-source = memory)
- load_ctrl_i  in  3  load code: 011 lb, 010 lh, 001 lw, 111 lbu, 110 lhu; other codes mean no load
- store_ctrl_i  in  2  store code: 11 sb, 10 sh, 01 sw, 00 none
- addr_i  in  ADDR_WIDTH  byte address from the ALU
- wdata_i  in  DATA_WIDTH  store data (rs2)
- busy_o  out  1  high from acceptance until done_o
- done_o  out  1  one-cycle completion pulse
- misalign_o  out  1  valid with done_o; access was misaligned and was not performed
- rdata_o  out  DATA_WIDTH  extended load result; valid from done_o and held until the next load completes
- mem_req_o  out  1  bus request
- mem_we_o  out  1  1 = write
- mem_addr_o  out  ADDR_WIDTH  word address {addr[ADDR_WIDTH-1:2], 2'b00}
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  DATA_WIDTH  lane-replicated write data
- mem_gnt_i  in  1  request accepted this cycle
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  DATA_WIDTH  read word

Behaviour:
- Reset (asynchronous, any state): state=IDLE. All outputs 0, including rdata_o. An in-flight transaction is abandoned and mem_req_o drops immediately. A late mem_rvalid_i is ignored.
- Operation decode at acceptance (IDLE and start_i=1):
  - store if store_ctrl_i != 00; store wins if is_load_i is also set.
  - else load if is_load_i=1 and load_ctrl_i is a valid load code.
  - else NOP.
- All operands are registered at acceptance; later input changes have no effect.
- start_i while busy_o=1 is ignored.
- FSM states: IDLE, REQ, WAIT_RSP, DONE.
  - IDLE to DONE: on NOP or misaligned access. No bus activity; misalign_o set for a misaligned access.
  - IDLE to REQ: otherwise.
  - REQ: mem_req_o=1; we/addr/be/wdata are held stable until mem_gnt_i. On gnt: a store goes to DONE, a load goes to WAIT_RSP.
  - WAIT_RSP: on mem_rvalid_i, capture the extracted data into rdata_o and go to DONE.
  - DONE: done_o=1 for exactly one cycle, then IDLE. busy_o=0 in DONE, so a new start_i is accepted in the DONE cycle.
- busy_o: 1 in REQ and WAIT_RSP, and in the cycle after acceptance.
- Latency, with start sampled at cycle 0:
  - store with immediate grant: req in cycle 1, done in cycle 2.
  - load with grant in cycle 1 and rvalid in cycle 2: done in cycle 3.
  - NOP or misaligned: done in cycle 1.
- Alignment, with off = addr[1:0]:
  - byte accesses are always aligned.
  - halfword accesses require off[0]=0.
  - word accesses require off=00.
- Store lanes:
  - sb: be = 4'b0001<<off; wdata = byte replicated ×4.
  - sh: be = 4'b0011<<off; wdata = halfword replicated ×2.
  - sw: be = 1111; wdata unchanged.
- Load extraction:
  - lb/lbu: byte at lane off, sign- or zero-extended.
  - lh/lhu: halfword at lane off[1], sign- or zero-extended.
  - lw: the full word.
  - mem_be_o for loads follows the same lane rule as stores; mem_we_o=0.
- rdata_o is unchanged by stores, NOPs and misaligned loads.
- mem_rvalid_i outside WAIT_RSP is ignored.
- mem_gnt_i outside REQ is ignored.

Test Plan:
- sw addr=0x100, wdata=0xDEADBEEF, gnt in the same cycle as req: mem_addr_o=0x100, be=1111, we=1; done_o in cycle 2; busy_o high in cycles 1–2 exclusive of done.
- sb addr=0x203, wdata=0x000000A5: mem_addr_o=0x200, be=1000, mem_wdata_o=0xA5A5A5A5.
- Loads with mem_rdata_i=0x80F07F81:
  - lb addr=0x0 → rdata_o=0xFFFFFF81.
  - lbu addr=0x3 → 0x00000080.
  - lh addr=0x2 → 0xFFFF80F0.
  - lhu addr=0x0 → 0x00007F81.
  - lw → 0x80F07F81.
- Grant delayed 3 cycles, then rvalid delayed 2 cycles: mem_req_o and address held stable throughout; exactly one done_o pulse; start_i pulses during busy are ignored.
- lw addr=0x102 and sh addr=0x101: no mem_req_o; done_o and misalign_o=1 in cycle 1; rdata_o keeps its previous value.
- Assert rst_ni low while in WAIT_RSP: mem_req_o, busy_o and rdata_o go to 0 immediately. An rvalid arriving after reset release produces no done_o.
